// File: rtl/button_debouncer.sv
// Two-flop synchroniser followed by a stable-level qualifier and a long-press flag.
// out follows in DEBOUNCE_CYCLES+2 enabled edges after a clean change; en low freezes all but the synchroniser.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned CNT_WIDTH       = 17,
  parameter int unsigned HOLD_CYCLES     = 10000000,
  parameter int unsigned HOLD_WIDTH      = 24
) (
  input  logic MHz10,
  input  logic nrst,
  input  logic en,
  input  logic in,
  output logic out,
  output logic held
);

  // Bit 1 of the encoding is the debounced level, so out decodes from a single flop.
  typedef enum logic [1:0] {
    LOW       = 2'b00,
    RISE_WAIT = 2'b01,
    HIGH      = 2'b11,
    FALL_WAIT = 2'b10
  } state_e;

  localparam logic [CNT_WIDTH-1:0]  CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_WIDTH-1:0] HOLD_MAX = HOLD_WIDTH'(HOLD_CYCLES);

  logic                  sync1_q, sync2_q;
  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [HOLD_WIDTH-1:0] hold_q, hold_d;
  logic                  held_q, held_d;

  always_ff @(posedge MHz10 or negedge nrst) begin
    if (!nrst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= in;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge MHz10 or negedge nrst) begin
    if (!nrst) begin
      state_q <= LOW;
      cnt_q   <= '0;
      hold_q  <= '0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      held_q  <= held_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    held_d  = held_q;
    if (en) begin
      unique case (state_q)
        LOW: begin
          if (sync2_q) begin
            state_d = RISE_WAIT;
            cnt_d   = '0;
          end
        end
        RISE_WAIT: begin
          if (!sync2_q) begin
            state_d = LOW;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = HIGH;
            cnt_d   = '0;
            hold_d  = '0;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
        HIGH: begin
          if (!sync2_q) begin
            state_d = FALL_WAIT;
            cnt_d   = '0;
          end else if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + HOLD_WIDTH'(1);
            if (hold_q + HOLD_WIDTH'(1) == HOLD_MAX) begin
              held_d = 1'b1;
            end
          end
        end
        FALL_WAIT: begin
          // A return to high keeps the hold count so a brief dropout does not restart the long press.
          if (sync2_q) begin
            state_d = HIGH;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = LOW;
            cnt_d   = '0;
            hold_d  = '0;
            held_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
        default: begin
          state_d = LOW;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    out  = state_q[1];
    held = held_q;
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with a run-length reference model checked every cycle.
module tb_button_debouncer;

  localparam int unsigned D = 4;
  localparam int unsigned H = 8;

  logic MHz10 = 1'b0;
  logic nrst  = 1'b0;
  logic en    = 1'b1;
  logic in_s  = 1'b0;
  logic out, held;

  int total = 0;
  int bad   = 0;

  button_debouncer #(
    .DEBOUNCE_CYCLES(D),
    .CNT_WIDTH      (17),
    .HOLD_CYCLES    (H),
    .HOLD_WIDTH     (24)
  ) dut (
    .MHz10(MHz10),
    .nrst (nrst),
    .en   (en),
    .in   (in_s),
    .out  (out),
    .held (held)
  );

  always #5 MHz10 = ~MHz10;

  // Model: out flips on the (D+1)th consecutive enabled edge whose synchronised sample
  // disagrees with out; held counts enabled edges spent settled high with agreeing samples.
  logic        p1_m = 1'b0, p2_m = 1'b0, s_m = 1'b0;
  logic        out_m = 1'b0, held_m = 1'b0;
  int unsigned run_m = 0, hold_m = 0;

  always @(posedge MHz10 or negedge nrst) begin
    if (!nrst) begin
      p1_m = 1'b0; p2_m = 1'b0;
      run_m = 0; hold_m = 0;
      out_m = 1'b0; held_m = 1'b0;
    end else begin
      s_m  = p2_m;
      p2_m = p1_m;
      p1_m = in_s;
      if (en) begin
        if (s_m != out_m) begin
          run_m++;
          if (run_m == D + 1) begin
            out_m  = s_m;
            run_m  = 0;
            hold_m = 0;
          end
        end else begin
          if (out_m && run_m == 0 && hold_m < H) hold_m++;
          run_m = 0;
        end
        held_m = out_m && (hold_m == H);
      end
    end
  end

  task automatic check(input string name, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%b expected=%b", name, $time, got, exp);
    end
  endtask

  // Advance n edges; after each, compare the DUT against the model.
  task automatic edges(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge MHz10);
      #2;
      if (nrst) begin
        check("model_out", out, out_m);
        check("model_held", held, held_m);
        check("held_implies_out", held && !out, 1'b0);
      end
    end
  endtask

  logic [63:0] pat_in;
  logic [63:0] pat_en;

  initial begin
    #3;
    check("reset_out", out, 1'b0);
    check("reset_held", held, 1'b0);
    @(posedge MHz10);
    @(posedge MHz10);
    #1 nrst = 1'b1;

    // Clean press: edge 0 is the first edge sampling in = 1.
    in_s = 1'b1;
    edges(6);
    check("press_out_edge5", out, 1'b0);
    edges(1);
    check("press_out_edge6", out, 1'b1);
    check("press_held_edge6", held, 1'b0);

    // Long press: held on the 8th HIGH edge (edge 14).
    edges(7);
    check("long_held_edge13", held, 1'b0);
    edges(1);
    check("long_held_edge14", held, 1'b1);

    // Release: out and held fall together on the 7th edge after release.
    in_s = 1'b0;
    edges(6);
    check("release_out_6", out, 1'b1);
    check("release_held_6", held, 1'b1);
    edges(1);
    check("release_out_7", out, 1'b0);
    check("release_held_7", held, 1'b0);
    edges(6);

    // Bounce: 1,1,1,0 then steady 1.
    in_s = 1'b1;
    edges(3);
    in_s = 1'b0;
    edges(1);
    in_s = 1'b1;
    for (int i = 0; i < 6; i++) begin
      edges(1);
      check("bounce_out_low", out, 1'b0);
    end
    edges(1);
    check("bounce_out_rise", out, 1'b1);
    in_s = 1'b0;
    edges(8);
    check("bounce_released", out, 1'b0);

    // Enable freeze mid-qualification.
    in_s = 1'b1;
    edges(4);
    check("freeze_pre", out, 1'b0);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      edges(1);
      check("freeze_out", out, 1'b0);
    end
    en = 1'b1;
    edges(2);
    check("freeze_resume_2", out, 1'b0);
    edges(1);
    check("freeze_resume_3", out, 1'b1);

    // Async reset while out and held are high.
    edges(9);
    check("pre_reset_held", held, 1'b1);
    #1 nrst = 1'b0;
    #1;
    check("async_rst_out", out, 1'b0);
    check("async_rst_held", held, 1'b0);
    edges(2);
    nrst = 1'b1;
    edges(6);
    check("requal_out_5", out, 1'b0);
    edges(1);
    check("requal_out_6", out, 1'b1);

    // Mixed en/in vectors, checked against the model only.
    pat_in = 64'h0FFF_F0F0_FFFF_3C00;
    pat_en = 64'hFFEF_FBFF_7FFF_FFDF;
    for (int i = 0; i < 64; i++) begin
      in_s = pat_in[i];
      en   = pat_en[i];
      edges(1);
    end
    en   = 1'b1;
    in_s = 1'b0;
    edges(20);
    check("final_out", out, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
